// File: rtl/regwr_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Pure declarations, no logic and no latency.
// Requester numbering doubles as the fixed round-robin order.
package regwr_arb_pkg;

  localparam int NUM_REQ  = 4;

  // Requester slots on the shared write port
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_LINK = 2;
  localparam int REQ_DBG  = 3;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regwr_port_arbiter_if.sv
// Handshake bundle between the writeback requesters and the write-port arbiter.
// Wires only, no latency.
// Requesters hold req_i high until served; the arbiter answers with a registered grant.
interface regwr_port_arbiter_if;
  import regwr_arb_pkg::*;

  logic [NUM_REQ-1:0] req_i;
  logic               done_i;
  logic [NUM_REQ-1:0] gnt_o;
  req_idx_t           gnt_idx_o;
  logic               gnt_valid_o;
  logic               preempt_o;

  // Requester side: drives requests and the owner's done flag
  modport master (
    output req_i,
    output done_i,
    input  gnt_o,
    input  gnt_idx_o,
    input  gnt_valid_o,
    input  preempt_o
  );

  // Arbiter side
  modport slave (
    input  req_i,
    input  done_i,
    output gnt_o,
    output gnt_idx_o,
    output gnt_valid_o,
    output preempt_o
  );

endinterface

// File: rtl/regwr_port_arbiter_decoder.sv
// 2:4 enabled decoder turning the registered owner index into a one-hot write enable.
// Purely combinational, zero latency.
// No backpressure; output is all zero whenever en_i is low.
module Decoder_2x4
  import regwr_arb_pkg::*;
(
  input  logic     en_i,
  input  req_idx_t a_i,
  output logic [3:0] y_o
);

  // One-hot decode gated by enable
  always_comb begin
    y_o = 4'b0000;
    if (en_i) begin
      y_o[a_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regwr_port_arbiter.sv
// Round-robin owner of the single register-file write port, with a hold timeout.
// Grant appears 1 cycle after request; handover between owners is back-to-back.
// An owner keeps the port until done_i, request drop, or MAX_HOLD cycles elapse.
module regwr_port_arbiter #(
  parameter int NUM_REQ  = 4,   // only 4 is supported (2-bit index)
  parameter int MAX_HOLD = 4,   // 1..15
  parameter int CNT_W    = 4    // 2**CNT_W must exceed MAX_HOLD
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  regwr_port_arbiter_if.slave bus
);
  import regwr_arb_pkg::*;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // First set bit of mask scanning start, start+1, ... (mod 4); bit 2 flags "found"
  function automatic logic [2:0] pick(input req_idx_t start, input logic [NUM_REQ-1:0] mask);
    logic     found;
    req_idx_t idx;
    req_idx_t cand;
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < 4; i++) begin
      cand = start + req_idx_t'(i);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  arb_state_t       state_q;
  req_idx_t         owner_q;
  req_idx_t         ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             gnt_valid_q;
  logic             preempt_q;

  logic               own_req_d;
  logic               at_limit_d;
  logic               rel_d;
  logic               timeout_d;
  logic [NUM_REQ-1:0] mask_rel_d;
  logic [2:0]         pick_idle_d;
  logic [2:0]         pick_next_d;

  // Release decision and next-owner candidates from the current inputs
  always_comb begin
    own_req_d  = bus.req_i[owner_q];
    at_limit_d = (hold_cnt_q == HOLD_LAST);
    rel_d      = bus.done_i | ~own_req_d | at_limit_d;
    // done wins over timeout, so a finishing owner is never flagged as preempted
    timeout_d  = at_limit_d & ~bus.done_i & own_req_d;
    // A timed-out owner still competes, but only after everyone else in the rotation
    mask_rel_d = bus.req_i;
    if (bus.done_i || !own_req_d) begin
      mask_rel_d[owner_q] = 1'b0;
    end
    pick_idle_d = pick(ptr_q, bus.req_i);
    pick_next_d = pick(owner_q + 2'd1, mask_rel_d);
  end

  // Grant FSM with registered grant, index, hold counter and preempt pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          preempt_q <= 1'b0;
          if (pick_idle_d[2]) begin
            state_q     <= GRANT;
            owner_q     <= pick_idle_d[1:0];
            hold_cnt_q  <= '0;
            gnt_valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (!rel_d) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            preempt_q  <= 1'b0;
          end else begin
            ptr_q      <= owner_q + 2'd1;
            preempt_q  <= timeout_d;
            hold_cnt_q <= '0;
            if (pick_next_d[2]) begin
              owner_q <= pick_next_d[1:0];
            end else begin
              state_q     <= IDLE;
              gnt_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_valid_q <= 1'b0;
          preempt_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_idx_o   = owner_q;
  assign bus.gnt_valid_o = gnt_valid_q;
  assign bus.preempt_o   = preempt_q;

  // Decode straight from flops so the write enables never glitch
  Decoder_2x4 u_dec (
    .en_i (gnt_valid_q),
    .a_i  (owner_q),
    .y_o  (bus.gnt_o)
  );

endmodule

// File: doc/regwr_port_arbiter.md
Name: regwr_port_arbiter

Overview:
- Round-robin arbiter that shares the single register-file write port among 4 requesters: ALU writeback, load writeback, link-register write and debug write.
- Produces a registered 2-bit grant index plus a one-hot write-enable vector. The one-hot vector comes from a 2:4 enabled decoder, with enable = grant valid.
- Sits between the pipeline writeback stage and the register file's write-enable decode.
- Bounds each grant with a hold timeout so that no requester can starve the others.

Parameters:
- NUM_REQ, 4, number of requesters. Fixed at 4 to match the 2-bit index. Other values are unsupported.
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant before forced release. Legal range is 1..15.
- CNT_W, 4, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_i  input  4  per-requester request level. Bit k is requester k. Held high while requester k wants the port.
- done_i  input  1  the current owner's last write this cycle. Ignored when gnt_valid_o=0.
- gnt_o  output  4  one-hot grant and write-enable vector, registered. All zero when no owner.
- gnt_idx_o  output  2  encoded owner index, registered.
- gnt_valid_o  output  1  a grant is active.
- preempt_o  output  1  one-cycle pulse: the owner lost the grant by timeout.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt_o=4'b0000, gnt_idx_o=2'b00, gnt_valid_o=0, preempt_o=0.
  - Deassertion takes effect at the next clock edge. Reset mid-grant drops the grant immediately; there is no completion handshake.
- Priority function pick(ptr, mask):
  - Returns the first set bit of mask scanning ptr, ptr+1, … mod 4.
  - Also returns "none" if mask=0.
- State IDLE:
  - If req_i!=0, the next edge loads owner=pick(ptr, req_i) and enters GRANT: gnt_valid_o=1, gnt_idx_o=owner, gnt_o=decode(owner), hold_cnt=0.
  - Latency from req_i rising to gnt_o is 1 cycle.
- State GRANT release condition, evaluated each cycle from current inputs:
  - rel = done_i OR !req_i[owner] OR (hold_cnt==MAX_HOLD-1).
  - timeout = (hold_cnt==MAX_HOLD-1) AND !done_i AND req_i[owner].
- State GRANT, rel=0: hold_cnt increments and the grant is unchanged.
- State GRANT, rel=1, back-to-back with no bubble:
  - ptr<=owner+1 (mod 4).
  - nxt=pick(owner+1, req_i'), where req_i' is req_i with the owner bit cleared if done_i or !req_i[owner]. Otherwise req_i' includes the owner.
  - If nxt exists: stay in GRANT with owner=nxt and hold_cnt=0.
  - Otherwise: go to IDLE with gnt_o=0 and gnt_valid_o=0.
  - preempt_o<=timeout for exactly one cycle, coincident with the new grant.
- Self re-grant: if the owner is the only requester and timed out, it is re-granted next cycle with hold_cnt=0 and preempt_o=1.
- MAX_HOLD=1: every grant lasts exactly 1 cycle, giving pure round-robin per cycle.
- Pointer wrap: owner 3 sets ptr=0.
- Simultaneous done_i and timeout: counts as done, so preempt_o=0.
- Invariants:
  - gnt_o is always one-hot or zero.
  - gnt_o==decode(gnt_idx_o) when gnt_valid_o=1.
  - A requester that drops req_i mid-grant loses the grant on the next edge.

Decomposition:
- Shared package regwr_arb_pkg:
  - typedef arb_state_t enum {IDLE, GRANT}.
  - typedef req_idx_t logic[1:0].
  - Constants NUM_REQ=4 and REQ_ALU=0, REQ_LOAD=1, REQ_LINK=2, REQ_DBG=3.
- Sub-module: the existing 2:4 enabled decoder (Decoder_2x4).
  - Instance driven by the registered owner index, with en = gnt_valid.
  - It generates the one-hot gnt_o from the registered index, so gnt_o stays glitch-free relative to the flops.
- Priority pick is a combinational function inside the arbiter.

Test Plan:
1. Reset then single requester: rst_ni low 2 cycles, then req_i=0010.
   - Required: one cycle later gnt_o=0010, gnt_idx_o=1, gnt_valid_o=1.
   - Assert rst_ni=0 mid-grant: gnt_o=0000 immediately, without waiting for the clock.
2. Round-robin fairness: req_i=1111 held, done_i pulsed each cycle of grant.
   - Required: owners 0,1,2,3,0 on consecutive cycles, no idle bubble, preempt_o=0 throughout.
3. Timeout with MAX_HOLD=4: req_i=0101, done_i=0.
   - Required: owner 0 held 4 cycles, then owner 2 with preempt_o=1 for 1 cycle.
   - Owner 2 held 4 cycles, then owner 0 again.
4. Sole requester timeout: req_i=1000, done_i=0.
   - Required: gnt_o=1000 continuously, preempt_o pulses every 4th cycle, hold_cnt restarts each time.
5. Request withdrawal and idle: owner 1, then req_i goes 0010→0000.
   - Required: the next edge gives gnt_o=0000, gnt_valid_o=0, state IDLE.
   - A subsequent req_i=0011 grants 2'b01? No: ptr=2, so pick scans 2,3,0 and grants owner 0, gnt_o=0001.
6. done_i/timeout coincidence: MAX_HOLD=2, req_i=0011, done_i=1 on the 2nd grant cycle.
   - Required: preempt_o=0 and the next owner is 1.
